// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard for hazard detection.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_mp_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                flush
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy;
  logic [NREG-1:0]           busy_nxt;

  // Assignment order encodes priority: write clears, issue sets, flush clears all.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
    end
    if (iss_en) busy_nxt[iss_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  // Later ports overwrite earlier ones, so the highest index wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else begin
      busy <= busy_nxt;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != '0))
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  assign iss_ready = ~busy[iss_rd];

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign ra = rd_addr[k*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    logic hit;

    always_comb begin
      data = regs[ra];
      bsy  = busy[ra];
      hit  = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == ra) && (ra != '0)) begin
          data = wr_data[j*XLEN +: XLEN];
          hit  = 1'b1;
        end
      end
      // A same-cycle issue to this register means a newer producer is pending.
      if (hit && !(iss_en && (iss_rd == ra))) bsy = 1'b0;
    end
`else
    assign data = regs[ra];
    assign bsy  = busy[ra];
`endif

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k]              = bsy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised self-checking bench for regfile_mp_sb (2R2W) against an array-based reference model.
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int NREG = 1 << AW;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic                flush;

  int n_chk  = 0;
  int n_fail = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];

  regfile_mp_sb #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] rdd(input int k);
    return rd_data[k*XLEN +: XLEN];
  endfunction

  task automatic idle();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int j, input int a, input logic [XLEN-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < NRD; k++) begin
      int a;
      logic [XLEN-1:0] d;
      bit b;
      bit hit;
      a   = int'(rd_addr[k*AW +: AW]);
      d   = m_regs[a];
      b   = m_busy[a];
      hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++)
        if (a != 0 && wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
          d = wr_data[j*XLEN +: XLEN];
          hit = 1'b1;
        end
      if (hit && !(iss_en && int'(iss_rd) == a)) b = 1'b0;
`endif
      chk($sformatf("rd_data%0d r%0d", k, a), rdd(k), d);
      chk($sformatf("rd_busy%0d r%0d", k, a), 32'(rd_busy[k]), 32'(b));
    end
    chk($sformatf("iss_ready r%0d", iss_rd), 32'(iss_ready), 32'(!m_busy[int'(iss_rd)]));
  endtask

  // Reference next state, written as the per-register priority list.
  task automatic model_update();
    bit nb [NREG];
    for (int r = 1; r < NREG; r++) begin
      bit wr_hit;
      wr_hit = 1'b0;
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == r) wr_hit = 1'b1;
      if (flush)                              nb[r] = 1'b0;
      else if (iss_en && int'(iss_rd) == r)   nb[r] = 1'b1;
      else if (wr_hit)                        nb[r] = 1'b0;
      else                                    nb[r] = m_busy[r];
    end
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
        m_regs[int'(wr_addr[j*AW +: AW])] = wr_data[j*XLEN +: XLEN];
    for (int r = 1; r < NREG; r++) m_busy[r] = nb[r];
  endtask

  task automatic step();
    #1;
    check_model();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    set_rd(0, 3); set_rd(1, 17); iss_rd = 5'd9;
    #1;
    chk("reset rd_data0", rdd(0), 32'h0);
    chk("reset rd_busy", 32'(rd_busy), 32'h0);
    chk("reset iss_ready", 32'(iss_ready), 32'h1);
    rst_n = 1'b1;
    idle();
    step();

    // x0 is hardwired
    set_wr(0, 0, 32'hDEADBEEF); iss_en = 1'b1; iss_rd = '0;
    step();
    idle();
    #1;
    chk("x0 rd_data", rdd(0), 32'h0);
    chk("x0 rd_busy", 32'(rd_busy[0]), 32'h0);
    chk("x0 iss_ready", 32'(iss_ready), 32'h1);
    step();

    // two ports hit r5, port 1 wins
    set_wr(0, 5, 32'h11); set_wr(1, 5, 32'h22);
    step();
    idle(); set_rd(0, 5);
    #1;
    chk("multiwr r5", rdd(0), 32'h22);
    step();

    // scoreboard set / clear / issue beats write
    iss_en = 1'b1; iss_rd = 5'd7;
    step();
    idle(); set_rd(1, 7); iss_rd = 5'd7;
    #1;
    chk("sb r7 busy", 32'(rd_busy[1]), 32'h1);
    chk("sb r7 not ready", 32'(iss_ready), 32'h0);
    step();
    set_wr(0, 7, 32'h55);
    step();
    idle(); set_rd(1, 7);
    #1;
    chk("sb r7 cleared", 32'(rd_busy[1]), 32'h0);
    step();
    set_wr(1, 7, 32'h55); iss_en = 1'b1; iss_rd = 5'd7;
    step();
    idle(); set_rd(0, 7);
    #1;
    chk("sb r7 reissue busy", 32'(rd_busy[0]), 32'h1);
    chk("sb r7 data", rdd(0), 32'h55);
    step();

    // flush clears every pending producer
    foreach (m_busy[i]) if (i == 0) begin end
    iss_en = 1'b1; iss_rd = 5'd3; step();
    iss_rd = 5'd4; step();
    iss_rd = 5'd9; step();
    idle(); flush = 1'b1;
    step();
    idle();
    iss_rd = 5'd3; #1; chk("flush r3 ready", 32'(iss_ready), 32'h1);
    iss_rd = 5'd4; #1; chk("flush r4 ready", 32'(iss_ready), 32'h1);
    iss_rd = 5'd9; #1; chk("flush r9 ready", 32'(iss_ready), 32'h1);
    step();

    // same-cycle write and read of r12
    set_wr(0, 12, 32'h00001234);
    step();
    idle(); set_wr(0, 12, 32'hA5A5A5A5); set_rd(0, 12);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass r12 same", rdd(0), 32'hA5A5A5A5);
`else
    chk("nobypass r12 old", rdd(0), 32'h00001234);
`endif
    step();
    idle(); set_rd(0, 12);
    #1;
    chk("r12 next", rdd(0), 32'hA5A5A5A5);
    step();

    // random traffic with small address range to force collisions
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int k = 0; k < NRD; k++) set_rd(k, $urandom_range(0, 15));
      for (int j = 0; j < NWR; j++)
        if ($urandom_range(0, 1) == 1) set_wr(j, $urandom_range(0, 15), $urandom);
      iss_en = ($urandom_range(0, 2) == 0);
      iss_rd = AW'($urandom_range(0, 15));
      flush  = ($urandom_range(0, 15) == 0);
      step();
    end

    // asynchronous reset in the middle of activity
    idle();
    for (int r = 1; r < 8; r++) begin
      set_wr(0, r, 32'hC0DE0000 | r); iss_en = 1'b1; iss_rd = AW'(r + 8);
      step();
    end
    idle();
    set_rd(0, 3); set_rd(1, 12); iss_rd = 5'd12;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midreset rd_data0", rdd(0), 32'h0);
    chk("midreset rd_data1", rdd(1), 32'h0);
    chk("midreset rd_busy", 32'(rd_busy), 32'h0);
    chk("midreset iss_ready", 32'(iss_ready), 32'h1);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
